// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline constants and types for the 5-stage CPU.
//   REG_W / REG_ZERO / REG_RA : register-file index width, $zero, $ra
//   CYC_W / CNT_W             : performance counter widths
//   ex_t / mem_t / wb_t       : per-stage hazard tracking records
//   fwd_hit()                 : "this producer supplies this source register"
package cpu_pipe_pkg;

    localparam int              REG_W    = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'h1f;
    localparam int              CYC_W    = 32;
    localparam int              CNT_W    = 16;

    // EX needs its sources (for forwarding compares) plus destination info.
    typedef struct packed {
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rw;
        logic             we;
        logic             ld;
    } ex_t;

    // MEM keeps ld so a load still in MEM is never a forwarding source.
    typedef struct packed {
        logic [REG_W-1:0] rw;
        logic             we;
        logic             ld;
    } mem_t;

    typedef struct packed {
        logic [REG_W-1:0] rw;
        logic             we;
    } wb_t;

    // $zero is hardwired, so a write to it never produces a usable value.
    function automatic logic fwd_hit(logic we, logic [REG_W-1:0] rw,
                                     logic [REG_W-1:0] src);
        return we && (rw != REG_ZERO) && (rw == src);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: enable-gated up counter, async active-low clear.
//   W     : counter width
//   SAT   : 1 = stick at all-ones, 0 = wrap to zero
//   clk, rst_n, en_i : clock, async reset, count enable
//   cnt_o            : current count
module sat_counter #(
    parameter int W   = 16,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !(SAT && (cnt_q == '1)))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use stall, branch flush and
// performance counters for the 5-stage pipeline.
//   clk, rst_n                    : clock, async active-low reset
//   id_ra/id_rb/id_rw             : ID sources and final destination
//   id_we/id_ld/id_use_a/id_use_b : ID regwrite, load, reads ra, reads rb
//   ex_taken, halt                : EX redirect, syscall freeze
//   A_MEM/A_WB/B_MEM/B_WB         : operand forwarding selects
//   stall/bubble_ex/flush_id      : pipeline control
//   cycle_cnt/stall_cnt/flush_cnt : performance counters
import cpu_pipe_pkg::*;

module hazard_unit (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic [REG_W-1:0] id_rw,
    input  logic             id_we,
    input  logic             id_ld,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             ex_taken,
    input  logic             halt,
    output logic             A_MEM,
    output logic             A_WB,
    output logic             B_MEM,
    output logic             B_WB,
    output logic             stall,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_t  ex_q,  ex_d;
    mem_t mem_q, mem_d;
    wb_t  wb_q,  wb_d;

    logic lu;
    logic run;   // out of reset and not frozen: the pipeline advances this edge

    // Forwarding looks only at registered state. A load in MEM is excluded;
    // its consumer was stalled so it meets the load in WB instead.
    always_comb begin
        A_MEM = fwd_hit(mem_q.we & ~mem_q.ld, mem_q.rw, ex_q.ra);
        B_MEM = fwd_hit(mem_q.we & ~mem_q.ld, mem_q.rw, ex_q.rb);
        A_WB  = fwd_hit(wb_q.we, wb_q.rw, ex_q.ra) & ~A_MEM;
        B_WB  = fwd_hit(wb_q.we, wb_q.rw, ex_q.rb) & ~B_MEM;
    end

    always_comb begin
        lu = ex_q.ld && ex_q.we && (ex_q.rw != REG_ZERO) &&
             ((id_use_a && (id_ra == ex_q.rw)) ||
              (id_use_b && (id_rb == ex_q.rw)));
    end

    // rst_n gates the controls so every output reads 0 during reset, even
    // with halt or ex_taken asserted. A redirect makes the stalled consumer
    // dead, so ex_taken wins over lu.
    assign run       = rst_n & ~halt;
    assign stall     = rst_n & (halt | (lu & ~ex_taken));
    assign bubble_ex = run & (ex_taken | lu);
    assign flush_id  = run & ex_taken;

    always_comb begin
        wb_d.rw  = mem_q.rw;
        wb_d.we  = mem_q.we;
        mem_d.rw = ex_q.rw;
        mem_d.we = ex_q.we;
        mem_d.ld = ex_q.ld;
        ex_d.ra  = id_ra;
        ex_d.rb  = id_rb;
        ex_d.rw  = id_rw;
        ex_d.we  = id_we;
        ex_d.ld  = id_ld;
        if (bubble_ex) ex_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!halt) begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    sat_counter #(.W(CYC_W), .SAT(1'b0)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (run),
        .cnt_o (cycle_cnt)
    );

    sat_counter #(.W(CNT_W), .SAT(1'b1)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (run & lu & ~ex_taken),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W), .SAT(1'b1)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (run & ex_taken),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_ra, id_rb, id_rw;
    logic        id_we, id_ld, id_use_a, id_use_b, ex_taken, halt;
    logic        A_MEM, A_WB, B_MEM, B_WB, stall, bubble_ex, flush_id;
    logic [31:0] cycle_cnt;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .id_ra(id_ra), .id_rb(id_rb), .id_rw(id_rw),
        .id_we(id_we), .id_ld(id_ld), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .ex_taken(ex_taken), .halt(halt),
        .A_MEM(A_MEM), .A_WB(A_WB), .B_MEM(B_MEM), .B_WB(B_WB),
        .stall(stall), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the instruction occupying each stage, plus counter totals.
    typedef struct {
        logic [4:0] ra, rb, rw;
        bit         we, ld;
    } ins_t;

    typedef struct packed {
        logic        a_mem, a_wb, b_mem, b_wb, stall, bub, flush;
        logic [31:0] cyc;
        logic [15:0] sc, fc;
    } exp_t;

    localparam ins_t NOP = '{ra: 5'd0, rb: 5'd0, rw: 5'd0, we: 1'b0, ld: 1'b0};

    ins_t        m_ex = NOP, m_mem = NOP, m_wb = NOP;
    logic [31:0] m_cyc = 0;
    logic [15:0] m_sc = 0, m_fc = 0;
    exp_t        sb[$];
    int          n_chk = 0, n_err = 0;

    // Where operand src comes from: 0 register file, 1 MEM, 2 WB.
    // Nearest non-load older writer wins; $zero is never sourced.
    function automatic int src_of(logic [4:0] src);
        if (src == 5'd0) return 0;
        if (m_mem.we && !m_mem.ld && m_mem.rw == src) return 1;
        if (m_wb.we && m_wb.rw == src) return 2;
        return 0;
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    task automatic drive(input bit r, input bit h, input bit t,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                         input bit we, input bit ld, input bit ua, input bit ub);
        exp_t e;
        int   fa, fb;
        bit   lu;
        ins_t nxt;
        rst_n = r; halt = h; ex_taken = t;
        id_ra = ra; id_rb = rb; id_rw = rw;
        id_we = we; id_ld = ld; id_use_a = ua; id_use_b = ub;
        e  = '0;
        lu = m_ex.ld && m_ex.we && m_ex.rw != 0 &&
             ((ua && ra == m_ex.rw) || (ub && rb == m_ex.rw));
        if (r) begin
            fa = src_of(m_ex.ra);
            fb = src_of(m_ex.rb);
            e.a_mem = (fa == 1); e.a_wb = (fa == 2);
            e.b_mem = (fb == 1); e.b_wb = (fb == 2);
            e.stall = h || (lu && !t);
            e.bub   = !h && (t || lu);
            e.flush = !h && t;
            e.cyc = m_cyc; e.sc = m_sc; e.fc = m_fc;
        end
        sb.push_back(e);
        @(posedge clk);
        if (!r) begin
            m_ex = NOP; m_mem = NOP; m_wb = NOP;
            m_cyc = 0; m_sc = 0; m_fc = 0;
        end else if (!h) begin
            nxt = '{ra: ra, rb: rb, rw: rw, we: we, ld: ld};
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (t || lu) ? NOP : nxt;
            m_cyc = m_cyc + 1;
            if (lu && !t && m_sc != 16'hFFFF) m_sc = m_sc + 1;
            if (t && m_fc != 16'hFFFF) m_fc = m_fc + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle that has an expectation, compare all outputs.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("A_MEM",     {31'b0, A_MEM},     {31'b0, e.a_mem});
            check("A_WB",      {31'b0, A_WB},      {31'b0, e.a_wb});
            check("B_MEM",     {31'b0, B_MEM},     {31'b0, e.b_mem});
            check("B_WB",      {31'b0, B_WB},      {31'b0, e.b_wb});
            check("stall",     {31'b0, stall},     {31'b0, e.stall});
            check("bubble_ex", {31'b0, bubble_ex}, {31'b0, e.bub});
            check("flush_id",  {31'b0, flush_id},  {31'b0, e.flush});
            check("cycle_cnt", cycle_cnt,          e.cyc);
            check("stall_cnt", {16'b0, stall_cnt}, {16'b0, e.sc});
            check("flush_cnt", {16'b0, flush_cnt}, {16'b0, e.fc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; halt = 0; ex_taken = 0;
        id_ra = 0; id_rb = 0; id_rw = 0;
        id_we = 0; id_ld = 0; id_use_a = 0; id_use_b = 0;
        @(posedge clk); #1;
        // reset state, with halt/taken asserted to prove outputs stay 0
        drive(0, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // load-use on rb: stall, bubble, then consumer sees load in WB
        drive(1, 0, 0, 5'd1, 5'd2, 5'd5, 1, 1, 0, 0);
        drive(1, 0, 0, 5'd0, 5'd5, 5'd6, 1, 0, 0, 1);
        drive(1, 0, 0, 5'd0, 5'd5, 5'd6, 1, 0, 0, 1);
        idle(2);

        // ALU producer forwarded from MEM, then from WB
        drive(1, 0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
        drive(1, 0, 0, 5'd3, 5'd0, 5'd4, 1, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 5'd3, 5'd3, 5'd7, 1, 0, 1, 1);
        idle(2);

        // writes to $0 never forward
        drive(1, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
        drive(1, 0, 0, 5'd0, 5'd0, 5'd2, 1, 0, 1, 1);
        drive(1, 0, 0, 5'd0, 5'd0, 5'd2, 1, 0, 1, 1);
        idle(3);

        // taken branch coincident with load-use
        drive(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0);
        drive(1, 0, 1, 5'd5, 5'd5, 5'd6, 1, 0, 1, 1);
        idle(2);

        // halt for 10 cycles with a load-use pending in ID
        drive(1, 0, 0, 0, 0, 5'd4, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 5'd4, 0, 5'd6, 1, 0, 1, 0);
        drive(1, 0, 0, 5'd4, 0, 5'd6, 1, 0, 1, 0);
        idle(2);

        // cycle counter wrap
        force dut.u_cyc_cnt.cnt_q = 32'hFFFF_FFFE;
        #1 release dut.u_cyc_cnt.cnt_q;
        m_cyc = 32'hFFFF_FFFE;
        idle(4);

        // stall counter saturation
        force dut.u_stall_cnt.cnt_q = 16'hFFFF;
        #1 release dut.u_stall_cnt.cnt_q;
        m_sc = 16'hFFFF;
        drive(1, 0, 0, 0, 0, 5'd9, 1, 1, 0, 0);
        drive(1, 0, 0, 5'd9, 0, 5'd1, 1, 0, 1, 0);
        drive(1, 0, 0, 5'd9, 0, 5'd1, 1, 0, 1, 0);
        idle(1);

        // reset mid-stall discards the bubble
        drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 5'd7, 5'd1, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 5'd7, 5'd1, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 5'd7, 5'd1, 1, 0, 0, 1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end
        idle(2);

        @(negedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
